can_rx_mailbox: RTL and testbench

//  Receive-side message store for the CAN controller. It takes completed frames from the receiver
//  FSM, filters them through NFILT programmable ID/mask acceptance filters, and queues accepted

---
 rtl/can_rx_mailbox.sv | 201 ++++++++++++++++++++
 tb/tb_can_rx_mailbox.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_mailbox.sv
// can_rx_mailbox: receive-side message store for the CAN controller.
// Completed frames pass through NFILT ID/mask acceptance filters and
// accepted ones are queued in a DEPTH-entry FIFO that the CPU drains over
// the cs/rs/bytesel/d/q peripheral bus. Frames arriving while the FIFO is
// full are dropped and flagged in a sticky overflow bit.
module can_rx_mailbox #(
  parameter int DEPTH = 4,
  parameter int NFILT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [3:0]  rs,
  input  logic [3:0]  bytesel,
  input  logic [31:0] d,
  output logic [31:0] q,
  input  logic        frame_valid,
  input  logic [28:0] frame_id,
  input  logic        frame_ext,
  input  logic        frame_rtr,
  input  logic [3:0]  frame_dlc,
  input  logic [63:0] frame_data,
  output logic        irqrx,
  output logic        irqovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [2:0]  hit;
    logic [28:0] id;
    logic [63:0] data;
  } entry_t;

  // FIFO storage (not reset; validity is tracked by count)
  entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [1:0]    irqen;

  // Acceptance filter registers
  logic [28:0] fid   [NFILT];
  logic [28:0] fmsk  [NFILT];
  logic        fext  [NFILT];
  logic        fen   [NFILT];
  logic        fcmp  [NFILT];

  logic       reg_rd;
  logic       reg_wr;
  logic       ctrl_wr;
  logic       empty;
  logic       full;
  logic       flush;
  logic       ovf_clr;
  logic       do_pop;
  logic       do_push;
  logic       ovf_set;
  logic       accept;
  logic [2:0] hit_sel;
  logic [NFILT-1:0] filt_hit;
  entry_t     head;
  entry_t     new_entry;
  logic       unused_bits;

  assign reg_rd  = cs & (bytesel == 4'b0000);
  assign reg_wr  = cs & (bytesel == 4'b1111);
  assign ctrl_wr = reg_wr & (rs == 4'd1);
  assign flush   = ctrl_wr & d[1];
  assign ovf_clr = ctrl_wr & d[2];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // d[29] is reserved in every writable register
  assign unused_bits = d[29];

  // Acceptance: lowest-index hitting filter wins; no enabled filter means accept-all with hit=7
  always_comb begin
    logic any_en;
    logic found;
    logic [2:0] idx;
    any_en   = 1'b0;
    found    = 1'b0;
    idx      = 3'd7;
    filt_hit = '0;
    for (int k = 0; k < NFILT; k++) begin
      filt_hit[k] = fen[k]
                  & (((frame_id ^ fid[k]) & fmsk[k]) == 29'd0)
                  & (~fcmp[k] | (frame_ext == fext[k]));
      if (fen[k]) any_en = 1'b1;
      if (filt_hit[k] && !found) begin
        found = 1'b1;
        idx   = 3'(k);
      end
    end
    accept  = any_en ? found : 1'b1;
    hit_sel = any_en ? idx : 3'd7;
  end

  // Event arbitration: flush beats push/pop; a pop frees the slot for a same-cycle push
  assign do_pop  = ctrl_wr & d[0] & ~empty & ~flush;
  assign do_push = frame_valid & accept & (~full | do_pop) & ~flush;
  assign ovf_set = frame_valid & accept & full & ~do_pop & ~flush;

  assign new_entry = '{ext: frame_ext, rtr: frame_rtr, dlc: frame_dlc,
                       hit: hit_sel, id: frame_id, data: frame_data};

  // Write accepted frames into the slot at wr_ptr
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= new_entry;
  end

  // FIFO pointers, occupancy, overflow flag and interrupt enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irqen  <= 2'b00;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      // set wins over a same-cycle clear
      ovf <= ovf_set | (ovf & ~ovf_clr);
      if (ctrl_wr) irqen <= d[31:30];
    end
  end

  // Filter ID/mask registers, one pair per filter starting at rs4
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NFILT; k++) begin
        fid[k]  <= '0;
        fext[k] <= 1'b0;
        fmsk[k] <= '0;
        fen[k]  <= 1'b0;
        fcmp[k] <= 1'b0;
      end
    end else if (reg_wr) begin
      for (int k = 0; k < NFILT; k++) begin
        if (rs == 4'(4 + 2 * k)) begin
          fext[k] <= d[31];
          fid[k]  <= d[28:0];
        end
        if (rs == 4'(5 + 2 * k)) begin
          fen[k]  <= d[31];
          fcmp[k] <= d[30];
          fmsk[k] <= d[28:0];
        end
      end
    end
  end

  // Register read mux; head fields read 0 while the FIFO is empty
  always_comb begin
    entry_t     hv;
    logic [4:0] cnt5;
    hv   = empty ? '0 : head;
    cnt5 = 5'(count);
    q    = 32'h0;
    if (reg_rd) begin
      case (rs)
        4'd0: q = {hv.ext, hv.rtr, 1'b0, hv.id};
        // fields packed from bit 0 upward; the two top bits read 0
        4'd1: q = {2'b00, irqen, 9'h0, hv.hit, 3'h0, cnt5, ovf, full, ~empty, 1'b0, hv.dlc};
        4'd2: q = hv.data[31:0];
        4'd3: q = hv.data[63:32];
        default: begin
          for (int k = 0; k < NFILT; k++) begin
            if (rs == 4'(4 + 2 * k)) q = {fext[k], 2'b00, fid[k]};
            if (rs == 4'(5 + 2 * k)) q = {fen[k], fcmp[k], 1'b0, fmsk[k]};
          end
        end
      endcase
    end
  end

  assign irqrx  = irqen[0] & ~empty;
  assign irqovf = irqen[1] & ovf;

endmodule

// File: tb/tb_can_rx_mailbox.sv
// Directed bench for can_rx_mailbox (DEPTH=4, NFILT=2).
module tb_can_rx_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [3:0]  rs;
  logic [3:0]  bytesel;
  logic [31:0] d;
  logic [31:0] q;
  logic        frame_valid;
  logic [28:0] frame_id;
  logic        frame_ext;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        irqrx;
  logic        irqovf;

  int n_checks = 0;
  int n_errors = 0;

  can_rx_mailbox #(.DEPTH(4), .NFILT(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rs(rs), .bytesel(bytesel), .d(d), .q(q),
    .frame_valid(frame_valid), .frame_id(frame_id), .frame_ext(frame_ext),
    .frame_rtr(frame_rtr), .frame_dlc(frame_dlc), .frame_data(frame_data),
    .irqrx(irqrx), .irqovf(irqovf)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [1:0] ie, input logic [2:0] h,
                                     input logic [4:0] c, input logic o, input logic f,
                                     input logic ne, input logic [3:0] dl);
    return {2'b00, ie, 9'h0, h, 3'h0, c, o, f, ne, 1'b0, dl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; rs = 4'd0; bytesel = 4'b0000; d = 32'h0;
    frame_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [28:0] id, input logic ext, input logic [3:0] dlc,
                           input logic [63:0] data);
    frame_valid = 1'b1; frame_id = id; frame_ext = ext; frame_rtr = 1'b0;
    frame_dlc = dlc; frame_data = data;
  endtask

  task automatic set_wr(input logic [3:0] r, input logic [31:0] v);
    cs = 1'b1; rs = r; bytesel = 4'b1111; d = v;
  endtask

  task automatic push(input logic [28:0] id, input logic ext, input logic [3:0] dlc,
                      input logic [63:0] data);
    set_frame(id, ext, dlc, data);
    tick();
    idle();
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] v);
    set_wr(r, v);
    tick();
    idle();
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] v);
    cs = 1'b1; rs = r; bytesel = 4'b0000;
    #1;
    v = q;
    cs = 1'b0;
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] r, input logic [31:0] exp);
    logic [31:0] v;
    rd(r, v);
    check(tag, v, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    frame_id = '0; frame_ext = 1'b0; frame_rtr = 1'b0; frame_dlc = '0; frame_data = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    rd_check("rst_status", 4'd1, 32'h0);
    rd_check("rst_fmsk0", 4'd5, 32'h0);
    check("rst_irqrx", {31'h0, irqrx}, 32'h0);
    check("rst_irqovf", {31'h0, irqovf}, 32'h0);

    // 1: accept-all push and pop
    wr(4'd1, 32'hC000_0000);
    push(29'h123, 1'b0, 4'd2, 64'h0000_0000_0000_BBAA);
    rd_check("t1_id", 4'd0, 32'h0000_0123);
    rd_check("t1_data0", 4'd2, 32'h0000_BBAA);
    rd_check("t1_data1", 4'd3, 32'h0);
    rd_check("t1_status", 4'd1, st(2'b11, 3'd7, 5'd1, 1'b0, 1'b0, 1'b1, 4'd2));
    check("t1_irqrx_hi", {31'h0, irqrx}, 32'h1);
    set_wr(4'd1, 32'hC000_0001);
    #1;
    check("t1_irqrx_before_edge", {31'h0, irqrx}, 32'h1);
    tick();
    idle();
    check("t1_irqrx_lo", {31'h0, irqrx}, 32'h0);
    rd_check("t1_empty_id", 4'd0, 32'h0);
    wr(4'd1, 32'hC000_0001);
    rd_check("t1_pop_empty", 4'd1, st(2'b11, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0));

    // 2: filters, priority and ext compare
    wr(4'd4, 32'h0000_0100);
    wr(4'd5, 32'h8000_0700);
    push(29'h1FF, 1'b0, 4'd0, 64'h0);
    rd_check("t2_hit0", 4'd1, st(2'b11, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1, 4'd0));
    push(29'h2FF, 1'b0, 4'd0, 64'h0);
    rd_check("t2_drop", 4'd1, st(2'b11, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1, 4'd0));
    wr(4'd6, 32'h8000_0000);
    wr(4'd7, 32'hC000_0000);
    rd_check("t2_fid0_rb", 4'd4, 32'h0000_0100);
    rd_check("t2_fmsk0_rb", 4'd5, 32'h8000_0700);
    rd_check("t2_fmsk1_rb", 4'd7, 32'hC000_0000);
    push(29'h2FF, 1'b0, 4'd0, 64'h0);
    rd_check("t2_ext_mismatch", 4'd1, st(2'b11, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1, 4'd0));
    push(29'h2FF, 1'b1, 4'd3, 64'h0);
    push(29'h1FF, 1'b1, 4'd4, 64'h0);
    wr(4'd1, 32'hC000_0001);
    rd_check("t2_ext_id", 4'd0, 32'h8000_02FF);
    rd_check("t2_hit1", 4'd1, st(2'b11, 3'd1, 5'd2, 1'b0, 1'b0, 1'b1, 4'd3));
    wr(4'd1, 32'hC000_0001);
    rd_check("t2_prio_id", 4'd0, 32'h8000_01FF);
    rd_check("t2_prio_hit", 4'd1, st(2'b11, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1, 4'd4));
    wr(4'd1, 32'hC000_0002);
    wr(4'd4, 32'h0); wr(4'd5, 32'h0); wr(4'd6, 32'h0); wr(4'd7, 32'h0);
    rd_check("t2_flushed", 4'd1, st(2'b11, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0));

    // 3: fill to full; 5th frame overflows in the same cycle as a clear-ovf
    for (int i = 1; i <= 4; i++) push(29'(i), 1'b0, 4'(i), 64'(i));
    rd_check("t3_full", 4'd1, st(2'b11, 3'd7, 5'd4, 1'b0, 1'b1, 1'b1, 4'd1));
    set_frame(29'd5, 1'b0, 4'd5, 64'd5);
    set_wr(4'd1, 32'hC000_0004);
    tick();
    idle();
    rd_check("t3_ovf", 4'd1, st(2'b11, 3'd7, 5'd4, 1'b1, 1'b1, 1'b1, 4'd1));
    check("t3_irqovf", {31'h0, irqovf}, 32'h1);
    rd_check("t3_head", 4'd0, 32'h0000_0001);

    // 4: push+pop while full
    wr(4'd1, 32'hC000_0004);
    check("t4_irqovf_clr", {31'h0, irqovf}, 32'h0);
    set_frame(29'd6, 1'b0, 4'd6, 64'd6);
    set_wr(4'd1, 32'hC000_0001);
    tick();
    idle();
    rd_check("t4_pushpop", 4'd1, st(2'b11, 3'd7, 5'd4, 1'b0, 1'b1, 1'b1, 4'd2));
    rd_check("t4_head", 4'd0, 32'h0000_0002);
    repeat (3) wr(4'd1, 32'hC000_0001);
    rd_check("t4_tail", 4'd0, 32'h0000_0006);
    rd_check("t4_tail_data", 4'd2, 32'h0000_0006);
    wr(4'd1, 32'hC000_0001);

    // 5: flush beats push, then pointer wrap order
    for (int i = 7; i <= 9; i++) push(29'(i), 1'b0, 4'd1, 64'h0);
    set_frame(29'hA, 1'b0, 4'd1, 64'h0);
    set_wr(4'd1, 32'hC000_0002);
    tick();
    idle();
    rd_check("t5_flush", 4'd1, st(2'b11, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0));
    rd_check("t5_flush_id", 4'd0, 32'h0);
    for (int i = 0; i < 4; i++) push(29'(32'h10 + i), 1'b0, 4'd0, 64'h0);
    repeat (2) wr(4'd1, 32'hC000_0001);
    for (int i = 4; i < 6; i++) push(29'(32'h10 + i), 1'b0, 4'd0, 64'h0);
    for (int i = 2; i < 6; i++) begin
      rd_check($sformatf("t5_wrap%0d", i), 4'd0, 32'h10 + i);
      wr(4'd1, 32'hC000_0001);
    end
    rd_check("t5_drained", 4'd1, st(2'b11, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0));

    // 6: asynchronous reset mid-operation
    wr(4'd5, 32'h8000_0700);
    push(29'h55, 1'b0, 4'd1, 64'h0);
    rd_check("t6_pre", 4'd0, 32'h0000_0055);
    #2;
    reset = 1'b1;
    #1;
    rd_check("t6_id", 4'd0, 32'h0);
    rd_check("t6_status", 4'd1, 32'h0);
    rd_check("t6_fmsk0", 4'd5, 32'h0);
    check("t6_irqrx", {31'h0, irqrx}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    push(29'h2FF, 1'b0, 4'd0, 64'h0);
    rd_check("t6_accept_all", 4'd1, st(2'b00, 3'd7, 5'd1, 1'b0, 1'b0, 1'b1, 4'd0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
